// File: rtl/usb_tx_byte_sequencer_pkg.sv
// usb_tx_pkg: shared constants and types for the USB TX byte sequencer.
//   - PID codes (4-bit, as carried on tx_packet)
//   - sequencer state enum
//   - SYNC byte values and CRC16 constants
//   - PID classification helpers
package usb_tx_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam logic [7:0]  SYNC_LAST       = 8'h80;
  localparam logic [7:0]  SYNC_FILL       = 8'h00;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP
  } state_t;

  function automatic logic pid_is_data(input logic [3:0] p);
    return (p == PID_DATA0) || (p == PID_DATA1);
  endfunction

  function automatic logic pid_is_valid(input logic [3:0] p);
    case (p)
      PID_OUT, PID_IN, PID_DATA0, PID_DATA1,
      PID_ACK, PID_NAK, PID_STALL: return 1'b1;
      default:                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/usb_tx_byte_sequencer_if.sv
// Byte-sequencer bus: packet request from the protocol controller, FIFO
// head/pop, and the byte handshake with the parallel-to-serial shifter.
//   master: drives tx_start/tx_packet/tx_len, FIFO head, byte_req
//   slave : the sequencer; drives d_par/byte_valid/pop/eop_req/busy/bad_pid
interface usb_tx_byte_sequencer_if #(
  parameter int LEN_W = 7
);
  logic             tx_start;
  logic [3:0]       tx_packet;
  logic [LEN_W-1:0] tx_len;
  logic [7:0]       tx_packet_data;
  logic             byte_req;
  logic [7:0]       d_par;
  logic             byte_valid;
  logic             get_tx_packet_data;
  logic             eop_req;
  logic             busy;
  logic             bad_pid;

  modport master (
    output tx_start, tx_packet, tx_len, tx_packet_data, byte_req,
    input  d_par, byte_valid, get_tx_packet_data, eop_req, busy, bad_pid
  );

  modport slave (
    input  tx_start, tx_packet, tx_len, tx_packet_data, byte_req,
    output d_par, byte_valid, get_tx_packet_data, eop_req, busy, bad_pid
  );
endinterface

// File: rtl/usb_tx_byte_sequencer_crc16_byte.sv
// crc16_byte: combinational CRC16 (poly 0x8005, reflected) advance by one
// byte, LSB first.
//   i_crc  : current CRC register
//   i_byte : byte being folded in
//   o_crc  : CRC after the byte
module crc16_byte
  import usb_tx_pkg::*;
(
  input  logic [15:0] i_crc,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_crc
);

  // Byte-wide form: xor the byte into the low end, then shift 8 times.
  always_comb begin
    o_crc = i_crc ^ {8'h00, i_byte};
    for (int i = 0; i < 8; i++)
      o_crc = o_crc[0] ? ((o_crc >> 1) ^ CRC16_POLY_REFL) : (o_crc >> 1);
  end

endmodule

// File: rtl/usb_tx_byte_sequencer.sv
// usb_tx_byte_sequencer: registered byte sequencer for the USB transmitter.
// Walks SYNC -> PID -> payload (popped from FWFT FIFO) -> CRC16 lo/hi -> EOP,
// presenting one byte at a time to the serializer.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of usb_tx_byte_sequencer_if (all outputs registered)
module usb_tx_byte_sequencer
  import usb_tx_pkg::*;
#(
  parameter int SYNC_BYTES  = 1,
  parameter int MAX_PAYLOAD = 64,
  parameter int LEN_W       = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  usb_tx_byte_sequencer_if.slave  bus
);

  localparam int              SC_W       = (SYNC_BYTES > 1) ? $clog2(SYNC_BYTES) : 1;
  localparam logic [SC_W-1:0] SC_LAST    = SC_W'(SYNC_BYTES - 1);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_PAYLOAD);
  localparam logic [7:0]      SYNC_FIRST = (SYNC_BYTES == 1) ? SYNC_LAST : SYNC_FILL;

  state_t           r_state,    w_state_nxt;
  logic [3:0]       r_pid,      w_pid_nxt;
  logic [LEN_W-1:0] r_rem,      w_rem_nxt;
  logic [SC_W-1:0]  r_sync_cnt, w_sync_cnt_nxt;
  logic [15:0]      r_crc,      w_crc_nxt;
  logic [7:0]       r_d_par,    w_d_par_nxt;
  logic             r_byte_valid, w_byte_valid_nxt;
  logic             r_get,      w_get_nxt;
  logic             r_eop,      w_eop_nxt;
  logic             r_busy,     w_busy_nxt;
  logic             r_bad_pid,  w_bad_pid_nxt;

  logic [15:0]      w_crc_upd;
  logic [SC_W-1:0]  w_sync_inc;
  logic             w_take;

  // d_par always holds the byte being consumed, so it feeds the CRC directly.
  crc16_byte u_crc (
    .i_crc  (r_crc),
    .i_byte (r_d_par),
    .o_crc  (w_crc_upd)
  );

  assign w_take     = bus.byte_req & r_byte_valid;
  assign w_sync_inc = r_sync_cnt + SC_W'(1);

  always_comb begin
    w_state_nxt      = r_state;
    w_pid_nxt        = r_pid;
    w_rem_nxt        = r_rem;
    w_sync_cnt_nxt   = r_sync_cnt;
    w_crc_nxt        = r_crc;
    w_d_par_nxt      = r_d_par;
    w_byte_valid_nxt = r_byte_valid;
    w_get_nxt        = 1'b0;
    w_eop_nxt        = 1'b0;
    w_bad_pid_nxt    = 1'b0;

    case (r_state)
      IDLE: begin
        // byte_valid is low here, so a coincident byte_req is a no-op.
        if (bus.tx_start) begin
          if (pid_is_valid(bus.tx_packet)) begin
            w_pid_nxt        = bus.tx_packet;
            w_rem_nxt        = (bus.tx_len > LEN_MAX) ? LEN_MAX : bus.tx_len;
            w_sync_cnt_nxt   = '0;
            w_crc_nxt        = CRC16_INIT;
            w_d_par_nxt      = SYNC_FIRST;
            w_byte_valid_nxt = 1'b1;
            w_state_nxt      = SYNC;
          end else begin
            w_bad_pid_nxt    = 1'b1;
          end
        end
      end
      SYNC: if (w_take) begin
        if (r_sync_cnt == SC_LAST) begin
          w_d_par_nxt = {~r_pid, r_pid};
          w_state_nxt = PID;
        end else begin
          w_sync_cnt_nxt = w_sync_inc;
          w_d_par_nxt    = (w_sync_inc == SC_LAST) ? SYNC_LAST : SYNC_FILL;
        end
      end
      PID: if (w_take) begin
        if (!pid_is_data(r_pid)) begin
          w_byte_valid_nxt = 1'b0;
          w_eop_nxt        = 1'b1;
          w_d_par_nxt      = 8'h00;
          w_state_nxt      = EOP;
        end else if (r_rem == '0) begin
          w_d_par_nxt = ~r_crc[7:0];
          w_state_nxt = CRC_LO;
        end else begin
          w_d_par_nxt = bus.tx_packet_data;
          w_get_nxt   = 1'b1;
          w_state_nxt = DATA;
        end
      end
      DATA: if (w_take) begin
        w_crc_nxt = w_crc_upd;
        w_rem_nxt = r_rem - LEN_W'(1);
        if (r_rem != LEN_W'(1)) begin
          w_d_par_nxt = bus.tx_packet_data;
          w_get_nxt   = 1'b1;
        end else begin
          w_d_par_nxt = ~w_crc_upd[7:0];
          w_state_nxt = CRC_LO;
        end
      end
      CRC_LO: if (w_take) begin
        w_d_par_nxt = ~r_crc[15:8];
        w_state_nxt = CRC_HI;
      end
      CRC_HI: if (w_take) begin
        w_byte_valid_nxt = 1'b0;
        w_eop_nxt        = 1'b1;
        w_d_par_nxt      = 8'h00;
        w_state_nxt      = EOP;
      end
      // One-cycle state carrying the eop_req pulse; keeps busy high through it.
      EOP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pid        <= '0;
      r_rem        <= '0;
      r_sync_cnt   <= '0;
      r_crc        <= CRC16_INIT;
      r_d_par      <= 8'h00;
      r_byte_valid <= 1'b0;
      r_get        <= 1'b0;
      r_eop        <= 1'b0;
      r_busy       <= 1'b0;
      r_bad_pid    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pid        <= w_pid_nxt;
      r_rem        <= w_rem_nxt;
      r_sync_cnt   <= w_sync_cnt_nxt;
      r_crc        <= w_crc_nxt;
      r_d_par      <= w_d_par_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_get        <= w_get_nxt;
      r_eop        <= w_eop_nxt;
      r_busy       <= w_busy_nxt;
      r_bad_pid    <= w_bad_pid_nxt;
    end
  end

  assign bus.d_par              = r_d_par;
  assign bus.byte_valid         = r_byte_valid;
  assign bus.get_tx_packet_data = r_get;
  assign bus.eop_req            = r_eop;
  assign bus.busy               = r_busy;
  assign bus.bad_pid            = r_bad_pid;

endmodule

// File: doc/usb_tx_byte_sequencer.md
Name: usb_tx_byte_sequencer

Overview:
- Registered byte-level sequencer for the USB transmitter; successor to the combinational byte selector.
- Walks a full packet: SYNC byte(s) -> PID -> payload from the TX FIFO -> CRC16 low/high -> EOP request.
- Computes the data CRC16 internally and pops the FIFO itself.
- Sits between the TX FIFO / protocol controller and the parallel-to-serial shift register that generates `byte_req`.

Parameters:
- SYNC_BYTES, 1, number of SYNC bytes sent (1 = full speed 0x80; >1 sends 0x00 repeated SYNC_BYTES-1 times, then 0x80).
- MAX_PAYLOAD, 64, maximum data payload in bytes.
- LEN_W, $clog2(MAX_PAYLOAD+1), width of `tx_len`.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tx_start  in  1  one-cycle request to begin a packet; sampled only in IDLE
- tx_packet  in  4  PID code, sampled with `tx_start`
- tx_len  in  LEN_W  payload byte count, sampled with `tx_start`; ignored for non-data PIDs
- tx_packet_data  in  8  FIFO head byte (first-word fall-through)
- byte_req  in  1  shift register consumed current `d_par`; pulse, at most every 2nd cycle
- d_par  out  8  byte presented to shift register
- byte_valid  out  1  `d_par` holds a byte of the current packet
- get_tx_packet_data  out  1  one-cycle FIFO pop
- eop_req  out  1  one-cycle pulse: last byte consumed, shift register must send EOP
- busy  out  1  high from the cycle after an accepted `tx_start` until the cycle after `eop_req`
- bad_pid  out  1  one-cycle pulse: `tx_start` with an unsupported PID was rejected

Behaviour:
- Reset: state IDLE; `d_par`=0x00; `byte_valid`, `get_tx_packet_data`, `eop_req`, `busy`, `bad_pid` = 0; CRC = 0xFFFF; counters = 0.
  - `rst` mid-packet aborts immediately; no `eop_req` is emitted.
- All outputs are registered.
- Handshake:
  - A `byte_req` in cycle N advances the state.
  - The next byte appears on `d_par` in cycle N+1.
  - `byte_req` while `byte_valid`=0 is ignored.
- PID byte = {~tx_packet, tx_packet}.
- Supported PIDs and their packet forms:
  - DATA0 0011, DATA1 1011: data packets (payload + CRC16).
  - ACK 0010, NAK 1010, STALL 1110: handshake, PID only.
  - OUT 0001, IN 1001: PID only.
  - Any other code: stay in IDLE, pulse `bad_pid`.
- State machine:
  - IDLE: on `tx_start` with a valid PID, latch PID and length, load `d_par` with the first SYNC byte, go to SYNC.
  - SYNC: a sync counter counts `byte_req`. After the last SYNC byte is consumed, `d_par` = PID byte, go to PID.
  - PID, on `byte_req`:
    - handshake/token PID -> EOP;
    - data PID with len=0 -> CRC_LO (`d_par` = CRC low byte);
    - otherwise -> DATA, with `d_par` = `tx_packet_data` and `get_tx_packet_data` pulsed the same cycle.
  - DATA, on `byte_req`:
    - fold the consumed byte into the CRC;
    - decrement the remaining count;
    - if bytes remain, load the next FIFO byte and pop; else go to CRC_LO.
  - CRC_LO, then CRC_HI: `d_par` = ~crc[7:0], then ~crc[15:8].
  - EOP: on the last `byte_req`, drop `byte_valid` and pulse `eop_req`, return to IDLE.
- CRC16:
  - Polynomial 0x8005 (x^16+x^15+x^2+1), reflected, bit-LSB-first, init 0xFFFF.
  - Updated one byte per consumed data byte.
  - Reset to 0xFFFF on every accepted `tx_start`.
  - Zero-length payload yields CRC bytes 0x00, 0x00.
- Boundaries:
  - `tx_start` while busy is ignored.
  - `tx_len` > MAX_PAYLOAD is clamped to MAX_PAYLOAD.
  - The FIFO is not checked for empty; the controller guarantees `tx_len` bytes are present.
  - `byte_req` and `tx_start` in the same IDLE cycle: `tx_start` wins.

Decomposition:
- Package usb_tx_pkg holds:
  - the PID code constants;
  - the state enum (IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP);
  - SYNC_LAST=0x80, SYNC_FILL=0x00;
  - CRC16_POLY_REFL=0xA001, CRC16_INIT=0xFFFF.
- Sub-module crc16_byte: combinational next-CRC from (crc, byte), instantiated once. The CRC register lives in the parent.

Test Plan:
- Reset, then ACK (0010), one `byte_req` every 8 cycles -> `d_par` sequence 0x80, 0xD2; `eop_req` pulses one cycle after the 2nd `byte_req`; `busy` clears the cycle after.
- DATA0 with len=0 -> 0x80, 0xC3, 0x00, 0x00; no `get_tx_packet_data` pulses.
- DATA1 with len=4, FIFO 0x00, 0x01, 0x02, 0x03:
  - bytes are 0x80, 0x4B, 0x00..0x03, then CRC;
  - exactly 4 pops, each coincident with its data byte loading;
  - CRC matches the bench bitwise model.
- SYNC_BYTES=4 build, NAK -> 0x00, 0x00, 0x00, 0x80, 0x5A.
- `tx_packet`=0101 -> `bad_pid` pulse, state stays IDLE. `tx_start` during an ongoing STALL packet -> ignored; the packet completes unchanged.
- `rst` asserted mid-DATA (byte 2 of 4) -> next cycle all outputs at reset values, no `eop_req`. A following DATA0 len=1 then produces correct CRC (CRC was reinitialised).
